// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
// Defaults assume a 27 MHz reference clock.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam int unsigned DEF_PLL_RST_CYCLES = 32;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 27000;
    localparam int unsigned DEF_STABLE_CYCLES  = 2700;
    localparam int unsigned DEF_MAX_RETRIES    = 4;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Asynchronous active-low reset clears both stages.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= 2'b00;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock qualification and release of the PLL-clocked
// reset, with bounded retries and a terminal fault state.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lock,
    output logic       pll_reset,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [7:0] relock_count
);

    localparam int unsigned CNT_MAX =
        max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first saw lock_s counts as stable cycle one.
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 2);
    localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRIES - 1);

    logic          lock_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    relock_q, relock_d;
    logic          pll_rst_q, pll_rst_d;
    logic          srst_n_q, srst_n_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;

    sync2 u_lock_sync (
        .clk  (clk),
        .rst_n(reset_n),
        .d_i  (lock),
        .q_o  (lock_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            relock_q  <= '0;
            pll_rst_q <= 1'b1;
            srst_n_q  <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            relock_q  <= relock_d;
            pll_rst_q <= pll_rst_d;
            srst_n_q  <= srst_n_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        unique case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    retry_d = retry_q + 1'b1;
                    state_d = (retry_q == RTY_LAST) ? ST_FAULT : ST_PLL_RST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                // A drop on the completing cycle still wins.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STB_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        pll_rst_d = 1'b0;
        srst_n_d  = 1'b0;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        unique case (state_d)
            ST_PLL_RST:   pll_rst_d = 1'b1;
            ST_WAIT_LOCK,
            ST_STABLE:    pll_rst_d = 1'b0;
            ST_RUN: begin
                srst_n_d = 1'b1;
                ready_d  = 1'b1;
            end
            ST_FAULT: begin
                pll_rst_d = 1'b1;
                fault_d   = 1'b1;
            end
            default:      pll_rst_d = 1'b1;
        endcase
    end

    assign pll_reset    = pll_rst_q;
    assign sys_reset_n  = srst_n_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       lock;
    logic       pll_reset;
    logic       sys_reset_n;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lock        (lock),
        .pll_reset   (pll_reset),
        .sys_reset_n (sys_reset_n),
        .ready       (ready),
        .fault       (fault),
        .relock_count(relock_count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    function automatic logic pick(input int w);
        case (w)
            0:       return pll_reset;
            1:       return sys_reset_n;
            default: return fault;
        endcase
    endfunction

    // Falling edges until the selected output equals v (bounded at 200).
    task automatic edges_until(input int w, input logic v, output int n);
        n = 0;
        while (pick(w) !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int m;
        int late;

        reset_n = 1'b0;
        lock    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pll", pll_reset, 1);
        check("rst_srn", sys_reset_n, 0);
        check("rst_rdy", ready, 0);
        check("rst_flt", fault, 0);
        check("rst_rc", relock_count, 0);

        reset_n = 1'b1;
        edges_until(0, 1'b0, n);
        check("pll_len", n, 4);
        repeat (10) @(negedge clk);
        lock = 1'b1;
        edges_until(1, 1'b1, n);
        check("lock_to_run", n, 10);
        check("run_rdy", ready, 1);
        check("run_pll", pll_reset, 0);
        check("run_rc", relock_count, 0);

        lock = 1'b0;
        edges_until(1, 1'b0, n);
        check("loss_lat", n, 3);
        check("loss_rdy", ready, 0);
        check("loss_pll", pll_reset, 1);
        check("loss_rc", relock_count, 1);
        edges_until(0, 1'b0, n);
        check("relock_pll_len", n, 4);
        lock = 1'b1;
        edges_until(1, 1'b1, n);
        check("relock_run", n, 10);

        @(negedge clk);
        #1 lock = 1'b0;
        #3 lock = 1'b1;
        repeat (5) @(negedge clk);
        check("glitch_rdy", ready, 1);
        check("glitch_rc", relock_count, 1);

        late = 0;
        for (int i = 0; i < 260; i++) begin
            lock = 1'b0;
            edges_until(1, 1'b0, m);
            lock = 1'b1;
            edges_until(1, 1'b1, n);
            if (m != 3 || n != 12) late++;
        end
        check("sat_relock_lat", late, 0);
        check("sat_rc", relock_count, 255);
        check("sat_rdy", ready, 1);

        lock = 1'b0;
        edges_until(1, 1'b0, n);
        lock = 1'b1;
        repeat (6) @(negedge clk);
        check("stb_pll", pll_reset, 0);
        check("stb_srn", sys_reset_n, 0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_pll", pll_reset, 1);
        check("arst_srn", sys_reset_n, 0);
        check("arst_rdy", ready, 0);
        check("arst_flt", fault, 0);
        check("arst_rc", relock_count, 0);

        lock = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        edges_until(0, 1'b0, n);
        check("unst_pll_len", n, 4);
        lock = 1'b1;
        repeat (5) @(negedge clk);
        lock = 1'b0;
        repeat (3) @(negedge clk);
        check("unst_srn", sys_reset_n, 0);
        lock = 1'b1;
        edges_until(1, 1'b1, n);
        check("unst_restart", n, 10);
        check("unst_rc", relock_count, 0);

        reset_n = 1'b0;
        lock    = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        edges_until(0, 1'b0, n);
        check("to_pll1", n, 4);
        edges_until(0, 1'b1, n);
        check("to_wait1", n, 20);
        check("to_flt_early", fault, 0);
        edges_until(0, 1'b0, n);
        check("to_pll2", n, 4);
        edges_until(2, 1'b1, n);
        check("to_wait2", n, 20);
        check("flt_pll", pll_reset, 1);
        lock = 1'b1;
        repeat (30) @(negedge clk);
        check("flt_hold", fault, 1);
        check("flt_hold_pll", pll_reset, 1);
        check("flt_hold_srn", sys_reset_n, 0);
        #2 reset_n = 1'b0;
        #1;
        check("flt_clr", fault, 0);
        check("flt_clr_pll", pll_reset, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_flt_pll", pll_reset, 1);
        check("post_flt_flt", fault, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
